// File: rtl/nibble_serial_adder_if.sv
// Command/result handshake bundle for nibble_serial_adder.
// master = requester/consumer side, slave = the adder controller.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done_valid;
  logic         done_ready;
  logic [W:0]   sum;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, busy, done_valid, sum
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, busy, done_valid, sum
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit ripple-carry slice, one nibble per
// cycle LSB first, threading the carry through a register between cycles.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  parameter int IDXW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Explicit full-adder chain so the shared slice is a true ripple-carry adder.
  function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] r;
    logic       cy;
    cy = c;
    r  = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      r[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (x[i] & cy) | (y[i] & cy);
    end
    r[4] = cy;
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W:0]      sum_q, sum_d;

  logic [3:0]      slice_a_s;
  logic [3:0]      slice_b_s;
  logic [4:0]      slice_s;
  logic [W:0]      sum_write_s;
  logic            last_s;

  // Select the operand nibbles addressed by idx (one-hot AND-OR mux).
  always_comb begin
    slice_a_s = 4'h0;
    slice_b_s = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      slice_a_s = slice_a_s | (a_q[4*n +: 4] & {4{idx_q == IDXW'(n)}});
      slice_b_s = slice_b_s | (b_q[4*n +: 4] & {4{idx_q == IDXW'(n)}});
    end
  end

  assign slice_s = rca4(slice_a_s, slice_b_s, carry_q);
  assign last_s  = (idx_q == IDXW'(NIBBLES - 1));

  // Current sum with the addressed nibble replaced by the slice result.
  always_comb begin
    sum_write_s = sum_q;
    for (int n = 0; n < NIBBLES; n++) begin
      sum_write_s[4*n +: 4] = (idx_q == IDXW'(n)) ? slice_s[3:0] : sum_q[4*n +: 4];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          sum_d   = {(W+1){1'b0}};
          idx_d   = {IDXW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d = slice_s[4];
        sum_d   = sum_write_s;
        if (last_s) begin
          sum_d[W] = slice_s[4];
          idx_d    = {IDXW{1'b0}};
          state_d  = ST_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.done_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDXW{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDXW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {(W+1){1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done_valid  = (state_q == ST_DONE);
  assign bus.sum         = sum_q;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequencing controller that performs a wide addition (4*NIBBLES bits) by time-multiplexing one 4-bit ripple-carry adder slice, one nibble per cycle, least-significant nibble first. It latches the operands, steps the nibble index, threads the carry between cycles through a carry register, and assembles the result. Sits between a requesting datapath and the shared 4-bit full-adder chain, with valid/ready handshakes on both the command side and the result side.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.
IDXW, 4, width of the internal nibble index counter; must satisfy 2**IDXW >= NIBBLES.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-high.
start_valid  input  1  requester presents a command.
start_ready  output  1  block can accept a command; high only in IDLE.
a  input  W  operand A; sampled only on an accept.
b  input  W  operand B; sampled only on an accept.
cin  input  1  carry-in to nibble 0; sampled only on an accept.
busy  output  1  high in RUN and DONE.
done_valid  output  1  result valid; high only in DONE.
done_ready  input  1  consumer accepts the result.
sum  output  W+1  result; sum[W] is the final carry-out.

Behaviour:
- Reset: when rst=1 at an edge -> state IDLE; idx=0; carry register=0; operand registers=0; sum=0; done_valid=0; busy=0; start_ready=1 after that edge. Reset mid-RUN or mid-DONE aborts with no result produced; rst has priority over every other event.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1. Accept = start_valid & start_ready at an edge. On accept: latch a, b, cin into the operand and carry registers, clear sum, set idx=0, go to RUN. With no accept, stay in IDLE.
- RUN: start_ready=0, busy=1. The slice adds a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry register. At each edge:
  - write the 4-bit slice sum into sum[4*idx+3:4*idx];
  - write the slice carry-out into the carry register;
  - idx increments by 1.
  On the edge where idx==NIBBLES-1: also write the slice carry-out into sum[W], go to DONE, and reset idx to 0.
- Latency: accept at edge k; RUN occupies edges k+1..k+NIBBLES; done_valid=1 from edge k+NIBBLES onward. NIBBLES=1 gives a single RUN cycle.
- DONE: done_valid=1, busy=1, start_ready=0. sum is held stable until the handshake. On done_valid & done_ready at an edge: go to IDLE and clear done_valid. sum keeps its value until the next accept.
- start_valid during RUN/DONE: ignored, no side effects. The requester must hold its command until start_ready is seen.
- done_ready in IDLE/RUN: ignored.
- No overlap: a new accept can occur at the earliest one cycle after the done handshake, since start_ready rises in IDLE.
- Arithmetic: unsigned, modulo 2**(W+1). The result always equals a+b+cin exactly, with no overflow loss thanks to sum[W].
- The slice is purely combinational. All outputs are registered or decoded from state, with no combinational path from inputs to outputs.

Test Plan:
- NIBBLES=4. Accept a=0x1234, b=0x4321, cin=1 with done_ready=1 -> done_valid high exactly 4 edges after the accept; sum=0x05556; back to IDLE the next edge.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 RUN cycles; sum=0x10000. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x1FFFF.
- Back-pressure: complete a=0x00F0, b=0x0F10, cin=0 with done_ready=0 for 6 cycles, and start_valid=1 with new operands throughout. Required: sum=0x01000 held stable, start_ready=0, new command not taken. Release done_ready -> IDLE, then the new command is accepted.
- Assert rst for one cycle during the 2nd RUN cycle -> next cycle IDLE, sum=0, done_valid=0, start_ready=1. A following a=0x0003, b=0x0004, cin=0 -> sum=0x00007, unaffected by the aborted state.
- Back-to-back: hold start_valid=1 and done_ready=1 continuously with random operands (≥200 commands). Required: each result matches a+b+cin; exactly one result per accept; no accept while busy=1.
- NIBBLES=1. a=0xF, b=0x1, cin=1 -> single RUN cycle; sum=0x11; done_valid one edge after the accept edge.
